// File: rtl/cla_share_pkg.sv
// Shared types and sizes for the cla_share_arb slice.
// Optional counters are enabled with `define CLA_SHARE_CNT_EN.
package cla_share_pkg;
  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cla_clk.sv
// Carry-lookahead adder in 4-bit groups; operands come from the caller's
// op registers, so the sum settles one cycle after they are loaded.
module cla_clk #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int NBLK = WIDTH / 4;

  logic blk_c [NBLK+1];

  assign blk_c[0] = ci;
  assign co       = blk_c[NBLK];

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    logic [3:0] g, p, c;
    logic       bg, bp;

    assign g = a[4*k +: 4] & b[4*k +: 4];
    assign p = a[4*k +: 4] ^ b[4*k +: 4];

    assign c[0] = blk_c[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);

    // group generate/propagate feed the inter-block lookahead chain
    assign bg = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
    assign bp = &p;

    assign blk_c[k+1]  = bg | (bp & c[0]);
    assign s[4*k +: 4] = p ^ c;
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: ptr picks the winner only when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/cla_share_arb.sv
// Round-robin sharing of one CLA between two requesters, IDLE->EXEC->DONE.
// `define CLA_SHARE_CNT_EN adds per-requester completion counters cnt0/cnt1.
module cla_share_arb
  import cla_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_ci,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_s,
  output logic               rsp_co
`ifdef CLA_SHARE_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
`endif
);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_ci_q, op_ci_d, op_id_q, op_id_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             rsp_co_q, rsp_co_d, rsp_id_q, rsp_id_d;

  logic [1:0]       grant, hs;
  logic             gid;
  logic [WIDTH-1:0] sum;
  logic             sum_co;

  rr_arb2 u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  cla_clk #(.WIDTH(WIDTH)) u_add (
    .a  (op_a_q),
    .b  (op_b_q),
    .ci (op_ci_q),
    .s  (sum),
    .co (sum_co)
  );

  assign hs  = (state_q == IDLE) ? (req_valid & grant) : 2'b00;
  assign gid = hs[1];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state; any unused encoding falls back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (|hs) ? EXEC : IDLE;
      EXEC:    state_d = (lat_cnt_q == 4'd0) ? DONE : EXEC;
      DONE:    state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = grant;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: op regs only move on a grant so the adder inputs stay quiet
  always_comb begin
    ptr_d     = ptr_q;
    lat_cnt_d = lat_cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_ci_d   = op_ci_q;
    op_id_d   = op_id_q;
    rsp_s_d   = rsp_s_q;
    rsp_co_d  = rsp_co_q;
    rsp_id_d  = rsp_id_q;
    if (|hs) begin
      op_a_d    = gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      op_b_d    = gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      op_ci_d   = req_ci[gid];
      op_id_d   = gid;
      ptr_d     = ~gid;
      lat_cnt_d = LAT_M1;
    end else if (state_q == EXEC) begin
      if (lat_cnt_q == 4'd0) begin
        rsp_s_d  = sum;
        rsp_co_d = sum_co;
        rsp_id_d = op_id_q;
      end else begin
        lat_cnt_d = lat_cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q     <= 1'b0;
      lat_cnt_q <= 4'd0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_ci_q   <= 1'b0;
      op_id_q   <= 1'b0;
      rsp_s_q   <= '0;
      rsp_co_q  <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      lat_cnt_q <= lat_cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_ci_q   <= op_ci_d;
      op_id_q   <= op_id_d;
      rsp_s_q   <= rsp_s_d;
      rsp_co_q  <= rsp_co_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign rsp_s  = rsp_s_q;
  assign rsp_co = rsp_co_q;
  assign rsp_id = rsp_id_q;

`ifdef CLA_SHARE_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (state_q == DONE && rsp_ready) begin
      if (rsp_id_q) cnt1_d = cnt1_q + 1'b1;
      else          cnt0_d = cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif
endmodule
